// File: rtl/led_breathe_pwm_if.sv
// Control strobes in, LED drive and debug state out, for the breathing PWM stage.
// The master side drives TICK/ENABLE; the slave side (the LED stage) drives O/DUTY/STATE.
interface led_breathe_pwm_if #(
  parameter int N         = 8,
  parameter int PWM_WIDTH = 8
);
  logic                 TICK;
  logic                 ENABLE;
  logic [N-1:0]         O;
  logic [PWM_WIDTH-1:0] DUTY;
  logic [1:0]           STATE;

  modport master (
    output TICK,
    output ENABLE,
    input  O,
    input  DUTY,
    input  STATE
  );

  modport slave (
    input  TICK,
    input  ENABLE,
    output O,
    output DUTY,
    output STATE
  );
endinterface

// File: rtl/led_breathe_pwm.sv
// Breathing PWM LED driver: duty ramps up/holds/ramps down/holds, one step per applied tick.
// O lags phase/DUTY by 1 CLK; no backpressure -- extra TICKs within a PWM period collapse into one.
module led_breathe_pwm #(
  parameter int N          = 8,
  parameter int PWM_WIDTH  = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  led_breathe_pwm_if.slave bus
);

  localparam logic [1:0] LO_HOLD = 2'd0;
  localparam logic [1:0] RAMP_UP = 2'd1;
  localparam logic [1:0] HI_HOLD = 2'd2;
  localparam logic [1:0] RAMP_DN = 2'd3;

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PWM_WIDTH-1:0] MAX       = '1;
  localparam logic [PWM_WIDTH-1:0] PH_ONE    = PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH:0]   MAX_W     = {1'b0, MAX};
  localparam logic [PWM_WIDTH:0]   STEP_W    = (PWM_WIDTH+1)'(STEP);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);

  logic [PWM_WIDTH-1:0] phase_q;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic [1:0]           state_q, state_d;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 tick_pend_q, tick_pend_d;
  logic [N-1:0]         o_q;
  logic                 apply;
  logic [PWM_WIDTH:0]   up_sum;

  // Steps only land on the last phase so the new duty starts cleanly at phase 0.
  assign apply  = bus.ENABLE && (phase_q == MAX) && (tick_pend_q || bus.TICK);
  assign up_sum = {1'b0, duty_q} + STEP_W;

  always_comb begin
    duty_d      = duty_q;
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    tick_pend_d = bus.ENABLE && !apply && (tick_pend_q || bus.TICK);

    if (apply) begin
      case (state_q)
        LO_HOLD, HI_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = (state_q == LO_HOLD) ? RAMP_UP : RAMP_DN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
        RAMP_UP: begin
          if (up_sum >= MAX_W) begin
            duty_d     = MAX;
            state_d    = HI_HOLD;
            hold_cnt_d = '0;
          end else begin
            duty_d = up_sum[PWM_WIDTH-1:0];
          end
        end
        default: begin
          // Saturate at zero instead of wrapping when STEP does not divide MAX.
          if ({1'b0, duty_q} <= STEP_W) begin
            duty_d     = '0;
            state_d    = LO_HOLD;
            hold_cnt_d = '0;
          end else begin
            duty_d = duty_q - STEP_W[PWM_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      phase_q     <= '0;
      duty_q      <= '0;
      state_q     <= LO_HOLD;
      hold_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      o_q         <= '0;
    end else begin
      phase_q     <= phase_q + PH_ONE;
      duty_q      <= duty_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      tick_pend_q <= tick_pend_d;
      o_q         <= {N{bus.ENABLE && (phase_q < duty_q)}};
    end
  end

  assign bus.O     = o_q;
  assign bus.DUTY  = duty_q;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_WIDTH=4, STEP=4, HOLD_TICKS=2.
module tb_led_breathe_pwm;

  logic CLK;
  logic RESETN;
  int   checks;
  int   errors;

  led_breathe_pwm_if #(.N(8), .PWM_WIDTH(4)) bus ();

  led_breathe_pwm #(
    .N(8), .PWM_WIDTH(4), .STEP(4), .HOLD_TICKS(2)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while ((int'(dut.phase_q) != p) && (n < 40)) begin
      cyc();
      n++;
    end
    if (n >= 40) check("phase_timeout", 32'(dut.phase_q), 32'(p));
  endtask

  task automatic tick_at(input int p);
    wait_phase(p);
    bus.TICK = 1'b1;
    cyc();
    bus.TICK = 1'b0;
  endtask

  task automatic count_high(input string tag, input int exp_hi, input logic chk_lag);
    int hi;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (bus.O === 8'hFF) hi++;
      if (chk_lag && k == 9)  check({tag, "_lag_hi"}, 32'(bus.O), 32'hFF);
      if (chk_lag && k == 12) check({tag, "_lag_lo"}, 32'(bus.O), 32'h00);
    end
    check({tag, "_count"}, 32'(hi), 32'(exp_hi));
  endtask

  int exp_s [12] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 0};
  int exp_d [12] = '{0, 0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};

  initial begin
    checks     = 0;
    errors     = 0;
    RESETN     = 1'b0;
    bus.TICK   = 1'b0;
    bus.ENABLE = 1'b0;

    // Reset state and phase restart
    #3;
    check("rst_O", 32'(bus.O), 0);
    check("rst_DUTY", 32'(bus.DUTY), 0);
    check("rst_STATE", 32'(bus.STATE), 0);
    cyc();
    RESETN = 1'b1;
    check("rel_phase0", 32'(dut.phase_q), 0);
    cyc();
    check("rel_phase1", 32'(dut.phase_q), 1);
    cyc();
    check("rel_phase2", 32'(dut.phase_q), 2);

    // Full breathing cycle, one tick per period
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick_at(3);
      wait_phase(0);
      check($sformatf("ramp%0d_STATE", i), 32'(bus.STATE), 32'(exp_s[i]));
      check($sformatf("ramp%0d_DUTY", i), 32'(bus.DUTY), 32'(exp_d[i]));
      if (i == 4)  count_high("pwm12", 12, 1'b1);
      if (i == 11) count_high("pwm0", 0, 1'b0);
    end

    // Three ticks in one period collapse to a single hold step
    tick_at(2);
    tick_at(5);
    tick_at(9);
    wait_phase(0);
    check("collapse_STATE", 32'(bus.STATE), 0);
    check("collapse_hold", 32'(dut.hold_cnt_q), 1);
    cyc();
    wait_phase(0);
    check("idle_STATE", 32'(bus.STATE), 0);
    // Tick exactly on phase==MAX with nothing pending
    wait_phase(15);
    bus.TICK = 1'b1;
    cyc();
    bus.TICK = 1'b0;
    check("maxtick_STATE", 32'(bus.STATE), 1);
    check("maxtick_pend", 32'(dut.tick_pend_q), 0);

    // Ramp to 8, then freeze with ENABLE low while ticking
    tick_at(3);
    wait_phase(0);
    check("en_pre4", 32'(bus.DUTY), 4);
    tick_at(3);
    wait_phase(0);
    check("en_pre8", 32'(bus.DUTY), 8);
    bus.ENABLE = 1'b0;
    cyc();
    check("dis_O_next", 32'(bus.O), 0);
    for (int i = 0; i < 5; i++) begin
      tick_at(3);
      check($sformatf("dis%0d_O", i), 32'(bus.O), 0);
      tick_at(15);
      check($sformatf("dis%0d_DUTY", i), 32'(bus.DUTY), 8);
      check($sformatf("dis%0d_STATE", i), 32'(bus.STATE), 1);
    end
    bus.ENABLE = 1'b1;
    cyc();
    wait_phase(0);
    check("reen_noTick_DUTY", 32'(bus.DUTY), 8);
    tick_at(3);
    wait_phase(0);
    check("reen_DUTY", 32'(bus.DUTY), 12);
    check("reen_STATE", 32'(bus.STATE), 1);

    // Mid-period tick: duty changes only at the boundary
    tick_at(3);
    wait_phase(14);
    check("mid_DUTY_held", 32'(bus.DUTY), 12);
    wait_phase(0);
    check("mid_DUTY_new", 32'(bus.DUTY), 15);
    check("mid_STATE", 32'(bus.STATE), 2);
    check("mid_O_prev15", 32'(bus.O), 0);
    wait_phase(14);
    check("mid_O_phase13", 32'(bus.O), 32'hFF);

    // Async reset mid-ramp-down
    tick_at(3);
    wait_phase(0);
    tick_at(3);
    wait_phase(0);
    tick_at(3);
    wait_phase(0);
    check("pre_rst_DUTY", 32'(bus.DUTY), 11);
    check("pre_rst_STATE", 32'(bus.STATE), 3);
    wait_phase(5);
    check("pre_rst_O", 32'(bus.O), 32'hFF);
    #4;
    RESETN = 1'b0;
    #1;
    check("arst_O", 32'(bus.O), 0);
    check("arst_DUTY", 32'(bus.DUTY), 0);
    check("arst_STATE", 32'(bus.STATE), 0);
    cyc();
    RESETN = 1'b1;
    check("arst_phase0", 32'(dut.phase_q), 0);
    cyc();
    check("arst_phase1", 32'(dut.phase_q), 1);
    cyc();
    check("arst_phase2", 32'(dut.phase_q), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
